branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BTAG_W, default 22, tag width in bits (PC[31:10]).
REQ-002 SHALL have parameter BIND_W, default 8, index width in bits (PC[9:2]); 2^BIND_W entries.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port fetch_pc  input  32  PC of the instruction in IF, used for lookup.
REQ-006 SHALL have port pred_taken  output  1  predict taken for fetch_pc.
REQ-007 SHALL have port pred_target  output  32  predicted target, valid when pred_taken=1.
REQ-008 SHALL have port upd_en  input  1  resolved-branch update strobe from the MEM stage, one cycle per branch.
REQ-009 SHALL have port upd_pc  input  32  PC of the resolved branch.
REQ-010 SHALL have port upd_taken  input  1  actual branch outcome.
REQ-011 SHALL have port upd_target  input  32  actual branch target address (baddr).
REQ-012 SHALL have port upd_mispred  input  1  the pipeline flushed for this branch; qualified by upd_en.
REQ-013 SHALL have port mispred_cnt  output  16  saturating count of mispredicts.

Function
REQ-014 SHALL hold 2^BIND_W entries; each entry has a valid bit, a tag[BTAG_W], a 2-bit state and a 32-bit target.
REQ-015 SHALL split PCs into tag = PC[31:10], index = PC[9:2], offset = PC[1:0]; offset SHALL be ignored.
REQ-016 Lookup SHALL be combinational: hit = valid[idx] && tag[idx]==fetch_pc tag.
REQ-017 pred_taken SHALL equal hit && state[1]; pred_target SHALL equal target[idx] when pred_taken=1, otherwise fetch_pc+4.
REQ-018 State encoding SHALL be NH=00, NS=01, TH=10, TS=11; states 1x predict taken.
REQ-019 On upd_en with a hit at upd_pc, state SHALL transition as follows: NH: taken->NS, not->NH; NS: taken->TS, not->NH; TS: taken->TH, not->NS; TH: taken->TH, not->TS.
REQ-020 On upd_en with a hit and upd_taken=1, target SHALL be overwritten with upd_target.
REQ-021 On upd_en with a miss (invalid entry or tag mismatch) and upd_taken=1, the entry SHALL be allocated: valid=1, tag=upd tag, state=TS, target=upd_target; any existing entry is replaced.
REQ-022 On upd_en with a miss and upd_taken=0, no entry SHALL change.
REQ-023 With upd_en=0, entry state SHALL hold.
REQ-024 Simultaneous lookup and update to the same index SHALL return the pre-edge contents (no bypass); the new contents SHALL be visible the following cycle.
REQ-025 mispred_cnt SHALL increment by 1 on each edge where upd_en && upd_mispred, and SHALL saturate at 16'hFFFF.
REQ-026 Update latency SHALL be one clock: a write at edge N SHALL be visible to lookup after edge N.

Reset
REQ-027 nRST low SHALL immediately clear all valid bits and mispred_cnt to 0, independent of CLK.
REQ-028 During and after reset, pred_taken SHALL be 0 and pred_target SHALL be fetch_pc+4 until an allocation occurs.
REQ-029 Tag, target and state arrays need not be reset; they SHALL never affect outputs while their valid bit is 0.
REQ-030 Reset asserted in the same cycle as upd_en SHALL win; no allocation and no count SHALL occur.

Verification
REQ-031 After reset, fetch_pc=0x0000_0040 -> pred_taken=0, pred_target=0x0000_0044.
REQ-032 Update upd_pc=0x0000_0040, taken=1, target=0x0000_0100 -> next cycle, fetch_pc=0x40 gives pred_taken=1, target=0x100 (state TS); a second taken update gives TH.
REQ-033 From TH, issue two not-taken updates -> TS then NS; pred_taken=0 after the second; a third not-taken update gives NH; a taken update gives NS, still predicting not-taken.
REQ-034 Alias check: allocate 0x0000_0040, then look up 0x0000_0440 (same index, different tag) -> pred_taken=0; a taken update at 0x440 replaces the entry, and 0x40 then misses.
REQ-035 Apply 65540 cycles with upd_en=1 and upd_mispred=1 -> mispred_cnt=0xFFFF and holds; assert nRST mid-cycle -> mispred_cnt=0 and all lookups miss with no clock edge.
REQ-036 Same-cycle lookup and allocate at 0x80 -> pred_taken=0 in that cycle and 1 in the next.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit hysteresis state per entry.
// Lookup is combinational; updates from the resolved-branch port land on the next edge.
module branch_predictor #(
    parameter int unsigned BTAG_W = 22,
    parameter int unsigned BIND_W = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispred,
    output logic [15:0] mispred_cnt
);

    localparam int unsigned ENTRIES = 1 << BIND_W;

    typedef enum logic [1:0] {
        ST_NH = 2'b00,
        ST_NS = 2'b01,
        ST_TH = 2'b10,
        ST_TS = 2'b11
    } state_e;

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [BTAG_W-1:0] tag_q    [ENTRIES];
    logic [BTAG_W-1:0] tag_d    [ENTRIES];
    state_e            state_q  [ENTRIES];
    state_e            state_d  [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [31:0]       target_d [ENTRIES];

    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;

    logic [BIND_W-1:0] f_idx;
    logic [BTAG_W-1:0] f_tag;
    logic              f_hit;
    logic [BIND_W-1:0] u_idx;
    logic [BTAG_W-1:0] u_tag;
    logic              u_hit;
    state_e            u_next;

    // Offset bits never participate in lookup or allocation.
    logic unused_offset;
    assign unused_offset = ^{fetch_pc[1:0], upd_pc[1:0]};

    always_comb begin
        f_idx = fetch_pc[2 +: BIND_W];
        f_tag = fetch_pc[31 -: BTAG_W];
        u_idx = upd_pc[2 +: BIND_W];
        u_tag = upd_pc[31 -: BTAG_W];
        f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    end

    always_comb begin
        pred_taken  = f_hit && ((state_q[f_idx] == ST_TH) || (state_q[f_idx] == ST_TS));
        pred_target = pred_taken ? target_q[f_idx] : (fetch_pc + 32'd4);
        mispred_cnt = cnt_q;
    end

    always_comb begin
        u_next = state_q[u_idx];
        unique case (state_q[u_idx])
            ST_NH:   u_next = upd_taken ? ST_NS : ST_NH;
            ST_NS:   u_next = upd_taken ? ST_TS : ST_NH;
            ST_TS:   u_next = upd_taken ? ST_TH : ST_NS;
            ST_TH:   u_next = upd_taken ? ST_TH : ST_TS;
            default: u_next = ST_NH;
        endcase
    end

    always_comb begin
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_d[i]  = valid_q[i];
            tag_d[i]    = tag_q[i];
            state_d[i]  = state_q[i];
            target_d[i] = target_q[i];
        end
        if (upd_en) begin
            if (u_hit) begin
                state_d[u_idx] = u_next;
                if (upd_taken) begin
                    target_d[u_idx] = upd_target;
                end
            end else if (upd_taken) begin
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                state_d[u_idx]  = ST_TS;
                target_d[u_idx] = upd_target;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (upd_en && upd_mispred && (cnt_q != '1)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
            cnt_q <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload arrays are gated by valid, so they carry no reset.
    always_ff @(posedge CLK) begin
        tag_q    <= tag_d;
        state_q  <= state_d;
        target_q <= target_d;
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: allocation, hysteresis, aliasing,
// same-cycle lookup/update ordering, counter saturation and async reset.
module tb_branch_predictor;

    logic        CLK;
    logic        nRST;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispred;
    logic [15:0] mispred_cnt;

    int errors;
    int checks;

    branch_predictor #(.BTAG_W(22), .BIND_W(8)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .fetch_pc   (fetch_pc),
        .pred_taken (pred_taken),
        .pred_target(pred_target),
        .upd_en     (upd_en),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .upd_mispred(upd_mispred),
        .mispred_cnt(mispred_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        fetch_pc = pc;
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_en      = 1'b1;
        upd_pc      = pc;
        upd_taken   = tk;
        upd_target  = tgt;
        upd_mispred = 1'b0;
        tick();
        upd_en = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        look(32'h0000_0040);
        tick();
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL reset_taken got=%b want=0", pred_taken);
        end
        checks++;
        if (pred_target !== 32'h0000_0044) begin
            errors++; $display("FAIL reset_target got=%h want=00000044", pred_target);
        end
        checks++;
        if (mispred_cnt !== 16'h0000) begin
            errors++; $display("FAIL reset_cnt got=%h want=0000", mispred_cnt);
        end
        #2 nRST = 1'b1;
        tick();
        look(32'h0000_0040);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0000_0044) begin
            errors++; $display("FAIL post_reset got=%b/%h want=0/00000044", pred_taken, pred_target);
        end
    endtask

    task automatic test_alloc();
        upd(32'h0000_0040, 1'b1, 32'h0000_0100);
        look(32'h0000_0040);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h0000_0100) begin
            errors++; $display("FAIL alloc_ts got=%b/%h want=1/00000100", pred_taken, pred_target);
        end
        look(32'h0000_0043);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h0000_0100) begin
            errors++; $display("FAIL offset_ignored got=%b/%h want=1/00000100", pred_taken, pred_target);
        end
        upd(32'h0000_0040, 1'b1, 32'h0000_0100);
        look(32'h0000_0040);
        checks++;
        if (pred_taken !== 1'b1) begin
            errors++; $display("FAIL alloc_th got=%b want=1", pred_taken);
        end
    endtask

    task automatic test_hysteresis();
        // TH -> TS
        upd(32'h0000_0040, 1'b0, 32'h0);
        look(32'h0000_0040);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h0000_0100) begin
            errors++; $display("FAIL hyst_ts got=%b/%h want=1/00000100", pred_taken, pred_target);
        end
        // TS -> NS
        upd(32'h0000_0040, 1'b0, 32'h0);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0000_0044) begin
            errors++; $display("FAIL hyst_ns got=%b/%h want=0/00000044", pred_taken, pred_target);
        end
        // NS -> NH
        upd(32'h0000_0040, 1'b0, 32'h0);
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL hyst_nh got=%b want=0", pred_taken);
        end
        // NH -> NS, target replaced on a taken hit
        upd(32'h0000_0040, 1'b1, 32'h0000_0200);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0000_0044) begin
            errors++; $display("FAIL hyst_nh_ns got=%b/%h want=0/00000044", pred_taken, pred_target);
        end
        // NS -> TS
        upd(32'h0000_0040, 1'b1, 32'h0000_0200);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h0000_0200) begin
            errors++; $display("FAIL hyst_ns_ts got=%b/%h want=1/00000200", pred_taken, pred_target);
        end
    endtask

    task automatic test_alias();
        look(32'h0000_0440);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0000_0444) begin
            errors++; $display("FAIL alias_miss got=%b/%h want=0/00000444", pred_taken, pred_target);
        end
        upd(32'h0000_0440, 1'b0, 32'h0000_0999);
        look(32'h0000_0040);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h0000_0200) begin
            errors++; $display("FAIL alias_nt_keep got=%b/%h want=1/00000200", pred_taken, pred_target);
        end
        upd(32'h0000_0440, 1'b1, 32'h0000_0300);
        look(32'h0000_0440);
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h0000_0300) begin
            errors++; $display("FAIL alias_replace got=%b/%h want=1/00000300", pred_taken, pred_target);
        end
        look(32'h0000_0040);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0000_0044) begin
            errors++; $display("FAIL alias_old_miss got=%b/%h want=0/00000044", pred_taken, pred_target);
        end
    endtask

    task automatic test_same_cycle();
        look(32'h0000_0080);
        upd_en     = 1'b1;
        upd_pc     = 32'h0000_0080;
        upd_taken  = 1'b1;
        upd_target = 32'h0000_0180;
        #1;
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0000_0084) begin
            errors++; $display("FAIL same_cycle_pre got=%b/%h want=0/00000084", pred_taken, pred_target);
        end
        tick();
        upd_en = 1'b0;
        #1;
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h0000_0180) begin
            errors++; $display("FAIL same_cycle_post got=%b/%h want=1/00000180", pred_taken, pred_target);
        end
    endtask

    task automatic test_no_update();
        upd_en      = 1'b0;
        upd_pc      = 32'h0000_00C0;
        upd_taken   = 1'b1;
        upd_target  = 32'h0000_0500;
        upd_mispred = 1'b1;
        tick();
        tick();
        look(32'h0000_00C0);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0000_00C4) begin
            errors++; $display("FAIL no_update_alloc got=%b/%h want=0/000000c4", pred_taken, pred_target);
        end
        checks++;
        if (mispred_cnt !== 16'h0000) begin
            errors++; $display("FAIL no_update_cnt got=%h want=0000", mispred_cnt);
        end
        upd_mispred = 1'b0;
    endtask

    task automatic test_mispred_sat();
        // Not-taken misses at an unused index: counting without touching entries.
        upd_pc      = 32'h0000_0FC0;
        upd_taken   = 1'b0;
        upd_en      = 1'b1;
        upd_mispred = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (mispred_cnt !== 16'd3) begin
            errors++; $display("FAIL cnt_small got=%h want=0003", mispred_cnt);
        end
        for (int i = 0; i < 65537; i++) tick();
        checks++;
        if (mispred_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL cnt_sat got=%h want=ffff", mispred_cnt);
        end
        tick();
        checks++;
        if (mispred_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL cnt_hold got=%h want=ffff", mispred_cnt);
        end
        upd_en      = 1'b0;
        upd_mispred = 1'b0;
        look(32'h0000_0440);
        checks++;
        if (pred_taken !== 1'b1) begin
            errors++; $display("FAIL pre_reset_hit got=%b want=1", pred_taken);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if (mispred_cnt !== 16'h0000) begin
            errors++; $display("FAIL async_cnt got=%h want=0000", mispred_cnt);
        end
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0000_0444) begin
            errors++; $display("FAIL async_miss_440 got=%b/%h want=0/00000444", pred_taken, pred_target);
        end
        look(32'h0000_0080);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0000_0084) begin
            errors++; $display("FAIL async_miss_80 got=%b/%h want=0/00000084", pred_taken, pred_target);
        end
        tick();
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_reset_wins();
        nRST        = 1'b0;
        upd_en      = 1'b1;
        upd_pc      = 32'h0000_0040;
        upd_taken   = 1'b1;
        upd_target  = 32'h0000_0700;
        upd_mispred = 1'b1;
        tick();
        tick();
        upd_en      = 1'b0;
        upd_mispred = 1'b0;
        #2 nRST = 1'b1;
        look(32'h0000_0040);
        checks++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0000_0044) begin
            errors++; $display("FAIL reset_wins_alloc got=%b/%h want=0/00000044", pred_taken, pred_target);
        end
        checks++;
        if (mispred_cnt !== 16'h0000) begin
            errors++; $display("FAIL reset_wins_cnt got=%h want=0000", mispred_cnt);
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        nRST        = 1'b0;
        fetch_pc    = '0;
        upd_en      = 1'b0;
        upd_pc      = '0;
        upd_taken   = 1'b0;
        upd_target  = '0;
        upd_mispred = 1'b0;
        test_reset();
        test_alloc();
        test_hysteresis();
        test_alias();
        test_same_cycle();
        test_no_update();
        test_mispred_sat();
        test_reset_wins();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
